spram_uart_reader: RTL and testbench

- Read-back engine. On a start command it streams a block of 16-bit SPRAM words out through the byte-wide UART transmit interface.
- Each word is sent as two bytes, high byte first.
- It is the reader/transmit counterpart to the SPRAM init writer and the UART receive path in the top level. It drives the SPRAM address and the tx side of the tx mux.

---
 rtl/spram_uart_reader_if.sv | 27 ++
 rtl/spram_uart_reader.sv | 133 +++++++++++++
 tb/tb_spram_uart_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spram_uart_reader_if.sv
// SPRAM read port plus the byte-wide UART transmit handshake.
// The reader is the master and drives the address and send strobe.
interface spram_uart_reader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_ready;

  modport master (
    output ram_addr,
    output tx_data,
    output tx_send,
    input  ram_rdata,
    input  tx_ready
  );

  modport slave (
    input  ram_addr,
    input  tx_data,
    input  tx_send,
    output ram_rdata,
    output tx_ready
  );
endinterface

// File: rtl/spram_uart_reader.sv
// Streams a block of 16-bit SPRAM words to the UART.
// Each word goes out as two bytes, high byte first.
module spram_uart_reader #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  spram_uart_reader_if.master bus
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SEND_HI,
    GUARD_HI,
    SEND_LO,
    GUARD_LO,
    NEXT
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [15:0]       word_q, word_d;
  logic              done_q, done_d;
  logic              send;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Address, count, latency counter, captured word and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      lat_q    <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      lat_q    <= lat_d;
      word_q   <= word_d;
      done_q   <= done_d;
    end
  end

  // Next state, datapath updates and the send strobe.
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    remain_d = remain_q;
    lat_d    = lat_q;
    word_d   = word_q;
    done_d   = 1'b0;
    send     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (word_count != '0) begin
            addr_d   = start_addr;
            remain_d = word_count;
            lat_d    = '0;
            state_d  = WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          word_d  = bus.ram_rdata;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (bus.tx_ready) begin
          send    = 1'b1;
          state_d = GUARD_HI;
        end
      end
      GUARD_HI: state_d = SEND_LO;
      SEND_LO: begin
        if (bus.tx_ready) begin
          send    = 1'b1;
          state_d = GUARD_LO;
        end
      end
      GUARD_LO: state_d = NEXT;
      NEXT: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort kills any strobe in flight this cycle and suppresses done.
    if (abort && state != IDLE) begin
      state_d = IDLE;
      send    = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign bus.ram_addr = addr_q;
  assign bus.tx_send  = send;
  assign bus.tx_data  = (state == SEND_LO) ? word_q[7:0] : word_q[15:8];

endmodule

// File: tb/tb_spram_uart_reader.sv
// Randomized bench for spram_uart_reader.
// Models SPRAM with read latency and a UART with a busy gap.
module tb_spram_uart_reader;

  localparam int RD_LAT = 2;
  localparam int WCYC   = RD_LAT + 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] start_addr;
  logic [14:0] word_count;
  logic        abort;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:16383];
  logic [13:0] addr_d;
  int          gap = 1;
  bit          hold = 1'b0;
  bit          saw_send = 1'b0;
  int          ucnt = 0;
  int          n_checks = 0;
  int          n_err = 0;

  spram_uart_reader_if #(.ADDR_W(14)) bus ();

  spram_uart_reader #(
    .ADDR_W(14),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // SPRAM: data for an address appears RD_LAT cycles after it is presented.
  always @(posedge clk) addr_d <= bus.ram_addr;
  assign bus.ram_rdata = mem[addr_d];

  // UART: ready drops the cycle after a send and stays low for gap cycles.
  always @(negedge clk) saw_send = bus.tx_send;
  always @(posedge clk) begin
    #1;
    if (!rst_n) ucnt = 0;
    else if (saw_send) ucnt = gap;
    else if (ucnt > 0) ucnt--;
    bus.tx_ready = (ucnt == 0) && !hold;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer: a=start address, n=words, g=UART gap, hold_n=cycles
  // ready is held low after capture, ab=abort/reset cycle, sp=cycle of a
  // stray start while busy, use_rst=reset instead of abort.
  task automatic run_xfer(input logic [13:0] a, input logic [14:0] n,
                          input int g, input int hold_n, input int ab,
                          input int sp, input bit use_rst);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] w;
    logic [13:0] ea;
    int first, done_c, ndone, lim;
    bit prev, aborted;
    first = -1; done_c = -1; ndone = 0; prev = 0; aborted = 0;
    for (int i = 0; i < int'(n); i++) begin
      w = mem[a + 14'(i)];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    gap = g;
    lim = int'(n) * (WCYC + 2 * g) + hold_n + 20;
    @(negedge clk);
    hold = (hold_n > 0);
    start = 1'b1; start_addr = a; word_count = n;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (hold_n > 0 && c == 2 + hold_n) hold = 1'b0;
      if (c == sp) begin
        start = 1'b1; start_addr = ~a; word_count = 15'd3;
      end
      if (use_rst && c == ab + 3) rst_n = 1'b1;
      if (c == ab && busy) begin
        aborted = 1'b1;
        if (use_rst) rst_n = 1'b0;
        else abort = 1'b1;
        #1;
        check("send_on_abort", 32'(bus.tx_send), 0);
      end
      if (use_rst && aborted && c >= ab && c < ab + 3) begin
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(bus.ram_addr), 0);
        check("rst_data", 32'(bus.tx_data), 0);
      end
      if (aborted && c == ab + 1) check("busy_after_abort", 32'(busy), 0);
      if (bus.tx_send) begin
        if (aborted) check("send_after_abort", 1, 0);
        check("ready_at_send", 32'(bus.tx_ready), 1);
        check("send_gap", 32'(prev), 0);
        check("busy_at_send", 32'(busy), 1);
        ea = a + 14'(got_q.size() / 2);
        check("ram_addr", 32'(bus.ram_addr), 32'(ea));
        got_q.push_back(bus.tx_data);
        if (first < 0) first = c;
      end
      prev = bus.tx_send;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
        check("busy_at_done", 32'(busy), 0);
      end
      if (done_c >= 0 && c > done_c + 2) break;
      if (aborted && c > ab + 8) break;
    end
    hold = 1'b0; abort = 1'b0; rst_n = 1'b1;
    if (aborted) begin
      check("done_after_abort", ndone, 0);
      check("abort_prefix", 32'(got_q.size() <= exp_q.size()), 1);
    end else begin
      check("done_count", ndone, 1);
      check("byte_count", got_q.size(), exp_q.size());
      if (g == 1) begin
        check("done_cycle", done_c, int'(n) * WCYC + 1 + hold_n);
        if (n != 0) check("first_send", first, RD_LAT + 1 + hold_n);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("byte", 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [13:0] a;
    logic [14:0] n;
    int g, h, ab, sp;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; word_count = '0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_send", 32'(bus.tx_send), 0);
    check("reset_data", 32'(bus.tx_data), 0);
    check("reset_addr", 32'(bus.ram_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[16] = 16'hA55A;
    run_xfer(14'h0010, 15'd1, 1, 0, 0, 0, 1'b0);
    mem[0] = 16'h0001; mem[1] = 16'h0002;
    mem[2] = 16'h0004; mem[3] = 16'h0007;
    run_xfer(14'h0000, 15'd4, 1, 0, 0, 0, 1'b0);
    mem[16383] = 16'h1234; mem[0] = 16'hBEEF;
    run_xfer(14'h3FFF, 15'd2, 1, 0, 0, 0, 1'b0);
    run_xfer(14'h0010, 15'd1, 1, 50, 0, 0, 1'b0);
    run_xfer(14'h0123, 15'd0, 1, 0, 0, 0, 1'b0);
    run_xfer(14'h0000, 15'd8, 1, 0, 11, 0, 1'b0);
    run_xfer(14'h0000, 15'd8, 1, 0, 11, 0, 1'b1);
    run_xfer(14'h0010, 15'd1, 1, 0, 0, 0, 1'b0);

    // Abort together with start in IDLE: start is dropped.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; word_count = 15'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_done", 32'(done), 0);
    @(negedge clk);
    check("abort_start_busy2", 32'(busy), 0);

    for (int t = 0; t < 30; t++) begin
      a = 14'($urandom);
      n = 15'($urandom_range(0, 6));
      g = $urandom_range(1, 3);
      h = (n != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      ab = (n != 0 && $urandom_range(0, 3) == 0) ?
           $urandom_range(6, int'(n) * 8 + 4) : 0;
      sp = (n != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      for (int k = 0; k < int'(n); k++) mem[a + 14'(k)] = 16'($urandom);
      run_xfer(a, n, g, h, ab, sp, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
